// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Holds an N_VARS-input Boolean function as a loadable truth table
//   (bit i = f(i)). Evaluates it with one cycle of latency and, on start,
//   sweeps every input combination in ascending order. Each minterm
//   (mode=0) or maxterm (mode=1) index is streamed out over a valid/ready
//   handshake, and the number of accepted terms is reported at the end.
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   tt_load, tt_in    load a new truth table (IDLE only; wins over start)
//   eval_in/eval_out  combination to evaluate / registered f(eval_in)
//   start, mode       begin sweep (IDLE only); mode is sampled on start
//   busy, done        sweep in progress / one-cycle end-of-sweep pulse
//   out_valid, out_index, out_ready   term stream handshake
//   term_count        terms accepted in the current/last sweep
module truth_table_sweeper #(
  parameter int unsigned         N_VARS  = 4,
  parameter int unsigned         TT_W    = 2**N_VARS,
  parameter logic [TT_W-1:0]     TT_INIT = 16'hAC3C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tt_load,
  input  logic [TT_W-1:0]   tt_in,
  input  logic [N_VARS-1:0] eval_in,
  output logic              eval_out,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              out_valid,
  output logic [N_VARS-1:0] out_index,
  input  logic              out_ready,
  output logic              done,
  output logic [N_VARS:0]   term_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [N_VARS-1:0] IDX_MAX = '1;

  state_t            r_state;
  logic [TT_W-1:0]   r_tt;
  logic [N_VARS-1:0] r_idx;
  logic              r_mode;
  logic              r_eval;
  logic              r_busy;
  logic              r_valid;
  logic [N_VARS-1:0] r_index;
  logic              r_done;
  logic [N_VARS:0]   r_count;

  // A term is a minterm in SOP mode (f=1) and a maxterm in POS mode (f=0).
  logic w_match;
  assign w_match = (r_tt[r_idx] != r_mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tt    <= TT_INIT;
      r_idx   <= '0;
      r_mode  <= 1'b0;
      r_eval  <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_index <= '0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_eval <= r_tt[eval_in];

      unique case (r_state)
        S_IDLE: begin
          if (tt_load) begin
            r_tt <= tt_in;
          end else if (start) begin
            r_mode  <= mode;
            r_idx   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (w_match) begin
            r_valid <= 1'b1;
            r_index <= r_idx;
            r_state <= S_EMIT;
          end else if (r_idx == IDX_MAX) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_EMIT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_count <= r_count + 1'b1;
            // The last index ends the sweep directly instead of wrapping.
            if (r_idx == IDX_MAX) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_SCAN;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign eval_out   = r_eval;
  assign busy       = r_busy;
  assign out_valid  = r_valid;
  assign out_index  = r_index;
  assign done       = r_done;
  assign term_count = r_count;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;
  logic        tt_load;
  logic [15:0] tt_in;
  logic [3:0]  eval_in;
  logic        eval_out;
  logic        start;
  logic        mode;
  logic        busy;
  logic        out_valid;
  logic [3:0]  out_index;
  logic        out_ready;
  logic        done;
  logic [4:0]  term_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] ein;
    logic       eexp;
  } vec_t;

  vec_t vecs[16];
  int   exp_sop[$];
  int   exp_pos[$];
  int   exp_all[$];
  int   exp_none[$];

  truth_table_sweeper #(
    .N_VARS (4),
    .TT_INIT(16'hAC3C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tt_load   (tt_load),
    .tt_in     (tt_in),
    .eval_in   (eval_in),
    .eval_out  (eval_out),
    .start     (start),
    .mode      (mode),
    .busy      (busy),
    .out_valid (out_valid),
    .out_index (out_index),
    .out_ready (out_ready),
    .done      (done),
    .term_count(term_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one sweep. Inputs are driven and outputs sampled on falling edges.
  // stall_idx/stall_n hold out_ready low for stall_n cycles on that term;
  // glitch_cyc pulses tt_load+start while the sweep is running.
  task automatic do_sweep(input string name, input logic m, input int expq[$],
                          input int stall_idx, input int stall_n, input int glitch_cyc);
    int k;
    int cyc;
    int stalled;
    bit finished;
    k = 0;
    stalled = 0;
    finished = 0;
    @(negedge clk);
    mode = m;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, " busy after start"}, busy, 1'b1);
    for (cyc = 1; cyc <= 300 && !finished; cyc++) begin
      @(negedge clk);
      tt_load = 1'b0;
      start = 1'b0;
      if (cyc == glitch_cyc) begin
        tt_load = 1'b1;
        tt_in = 16'h0000;
        start = 1'b1;
        mode = ~m;
      end
      if (out_valid) begin
        if (out_index == 4'(stall_idx) && stalled < stall_n) begin
          chk({name, " held index"}, out_index, stall_idx);
          out_ready = 1'b0;
          stalled++;
        end else begin
          if (k < expq.size())
            chk({name, " index"}, out_index, expq[k]);
          else
            chk({name, " extra term"}, out_index, 32'hFFFF_FFFF);
          out_ready = 1'b1;
          k++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done) begin
        chk({name, " busy with done"}, busy, 1'b0);
        chk({name, " term_count"}, term_count, expq.size());
        chk({name, " terms seen"}, k, expq.size());
        chk({name, " sweep cycles"}, cyc, 16 + expq.size() + stall_n);
        finished = 1;
      end
    end
    if (!finished) chk({name, " timeout"}, 0, 1);
    tt_load = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk({name, " done one cycle"}, done, 1'b0);
    chk({name, " term_count held"}, term_count, expq.size());
  endtask

  initial begin
    logic ok;
    vecs[0]  = '{4'd0,  1'b0}; vecs[1]  = '{4'd1,  1'b0};
    vecs[2]  = '{4'd2,  1'b1}; vecs[3]  = '{4'd3,  1'b1};
    vecs[4]  = '{4'd4,  1'b1}; vecs[5]  = '{4'd5,  1'b1};
    vecs[6]  = '{4'd6,  1'b0}; vecs[7]  = '{4'd7,  1'b0};
    vecs[8]  = '{4'd8,  1'b0}; vecs[9]  = '{4'd9,  1'b0};
    vecs[10] = '{4'd10, 1'b1}; vecs[11] = '{4'd11, 1'b1};
    vecs[12] = '{4'd12, 1'b0}; vecs[13] = '{4'd13, 1'b1};
    vecs[14] = '{4'd14, 1'b0}; vecs[15] = '{4'd15, 1'b1};
    exp_sop = '{2, 3, 4, 5, 10, 11, 13, 15};
    exp_pos = '{0, 1, 6, 7, 8, 9, 12, 14};
    for (int i = 0; i < 16; i++) exp_all.push_back(i);

    rst_n = 1'b0;
    tt_load = 1'b0;
    tt_in = '0;
    eval_in = '0;
    start = 1'b0;
    mode = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset eval_out", eval_out, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_index", out_index, 4'd0);
    chk("reset done", done, 1'b0);
    chk("reset term_count", term_count, 5'd0);
    rst_n = 1'b1;

    // Evaluation against the reset table 16'hAC3C.
    for (int i = 0; i < 16; i++) begin
      eval_in = vecs[i].ein;
      @(negedge clk);
      chk($sformatf("eval %0d", vecs[i].ein), eval_out, vecs[i].eexp);
    end

    do_sweep("sop", 1'b0, exp_sop, -1, 0, -1);
    do_sweep("pos", 1'b1, exp_pos, -1, 0, -1);
    do_sweep("sop stall", 1'b0, exp_sop, 3, 3, -1);
    // Load/start pulse in mid-sweep must not disturb the sweep or the table.
    do_sweep("glitch", 1'b0, exp_sop, -1, 0, 5);
    eval_in = 4'd2;
    @(negedge clk);
    chk("table frozen while busy", eval_out, 1'b1);

    // Load and start together: load wins, no sweep begins.
    tt_in = 16'hFFFF;
    tt_load = 1'b1;
    start = 1'b1;
    @(negedge clk);
    tt_load = 1'b0;
    start = 1'b0;
    chk("load beats start busy", busy, 1'b0);
    eval_in = 4'd6;
    @(negedge clk);
    @(negedge clk);
    chk("loaded FFFF eval 6", eval_out, 1'b1);

    tt_in = 16'h0000;
    tt_load = 1'b1;
    @(negedge clk);
    tt_load = 1'b0;
    do_sweep("zero sop", 1'b0, exp_none, -1, 0, -1);
    do_sweep("zero pos", 1'b1, exp_all, -1, 0, -1);

    // Reset while a term is waiting in EMIT.
    @(negedge clk);
    mode = 1'b1;
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = out_valid;
    end
    chk("emit reached before reset", ok, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset busy", busy, 1'b0);
    chk("midreset out_valid", out_valid, 1'b0);
    chk("midreset term_count", term_count, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    eval_in = 4'd2;
    @(negedge clk);
    chk("table restored eval 2", eval_out, 1'b1);
    eval_in = 4'd0;
    @(negedge clk);
    chk("table restored eval 0", eval_out, 1'b0);
    chk("idle after reset", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
